// File: rtl/glyph_spi_streamer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : glyph_spi_streamer_if                                          |
// | Purpose  : Request channel into glyph_spi_streamer. A request is either  |
// |            a character code (glyph streamed from ROM) or a raw command   |
// |            byte for the OLED controller.                                 |
// | Signals  : in_valid  request valid             (master -> slave)         |
// |            in_ready  slave can accept          (slave  -> master)        |
// |            in_cmd    1 = command byte, 0 = char (master -> slave)         |
// |            in_data   char code / command byte  (master -> slave)         |
// |            invert    glyph inversion request, present only when          |
// |                      GLYPH_INVERT_EN is defined (master -> slave)        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface glyph_spi_streamer_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_cmd;
  logic [7:0] in_data;
`ifdef GLYPH_INVERT_EN
  logic       invert;

  modport master (output in_valid, output in_cmd, output in_data,
                  output invert, input in_ready);
  modport slave  (input in_valid, input in_cmd, input in_data,
                  input invert, output in_ready);
`else
  modport master (output in_valid, output in_cmd, output in_data,
                  input in_ready);
  modport slave  (input in_valid, input in_cmd, input in_data,
                  output in_ready);
`endif
endinterface
`default_nettype wire

// File: rtl/glyph_spi_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : glyph_spi_streamer                                            |
// | Purpose  : Streams 8-byte font glyphs (fetched from a 2 KB synchronous   |
// |            pROM) or single command bytes to an SSD1306-style SPI OLED.   |
// |            SPI mode 0, MSB first; DC = 1 for glyph data, 0 for commands. |
// | Params   : FONT_BASE  ROM byte address of glyph 0 (11 bit, wraps)        |
// |            SCLK_DIV   clk cycles per SCLK half-period (1..255)           |
// | Ports    : clk, reset_n        clock, synchronous active-low reset       |
// |            req (slave modport) valid/ready request channel              |
// |            busy                transaction or inter-frame gap running    |
// |            rom_ad/ce/oce/reset ROM read port; rom_dout one cycle later   |
// |            spi_sclk/mosi/cs_n/dc  OLED SPI link                          |
// | Option   : define GLYPH_INVERT_EN to add req.invert; glyph bytes are     |
// |            then XORed with 8'hFF (commands are never inverted).          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module glyph_spi_streamer #(
  parameter logic [10:0] FONT_BASE = 11'h000,
  parameter int unsigned SCLK_DIV  = 4
) (
  input  wire                  clk,
  input  wire                  reset_n,
  glyph_spi_streamer_if.slave  req,
  output logic                 busy,
  output logic [10:0]          rom_ad,
  output logic                 rom_ce,
  output logic                 rom_oce,
  output logic                 rom_reset,
  input  wire  [7:0]           rom_dout,
  output logic                 spi_sclk,
  output logic                 spi_mosi,
  output logic                 spi_cs_n,
  output logic                 spi_dc
);

  localparam logic [7:0] c_div_last = 8'(SCLK_DIV - 1);
  localparam logic [8:0] c_gap_last = 9'(2 * SCLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [7:0]  r_shift;       // byte currently on the wire
  logic [7:0]  r_pref;        // next glyph byte, fetched ahead of time
  logic [7:0]  r_inv_mask;    // 8'hFF when this glyph is inverted
  logic [2:0]  r_bit;         // index of the bit currently driven on MOSI
  logic [3:0]  r_bytes_left;  // bytes still to send, including current one
  logic [7:0]  r_div;         // clk count within the current SCLK half
  logic [8:0]  r_gap;         // clk count within the cs_n-high gap
  logic        r_started;     // cs_n has been dropped for this frame
  logic        r_pf_issue;    // prefetch read strobed this cycle
  logic        r_pf_cap;      // prefetch data is on rom_dout this cycle
  logic [10:0] r_rom_ad;
  logic        r_rom_ce;
  logic        r_sclk;
  logic        r_mosi;
  logic        r_cs_n;
  logic        r_dc;

  logic        w_accept;
  logic        w_half_done;
  logic        w_last;
  logic        w_gap_done;
  logic [7:0]  w_invert_mask;

`ifdef GLYPH_INVERT_EN
  assign w_invert_mask = (req.invert && !req.in_cmd) ? 8'hFF : 8'h00;
`else
  assign w_invert_mask = 8'h00;
`endif

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ------------------------------------------------------------------------
  // Next-state logic and control strobes
  // ------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_half_done  = 1'b0;
    w_last       = 1'b0;
    w_gap_done   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_accept = req.in_valid;
        if (req.in_valid) begin
          w_next_state = req.in_cmd ? S_SHIFT : S_FETCH;
        end
      end
      S_FETCH: begin
        w_next_state = S_LOAD;
      end
      S_LOAD: begin
        w_next_state = S_SHIFT;
      end
      S_SHIFT: begin
        // The first SHIFT cycle only drops cs_n; SCLK timing starts after.
        w_half_done = r_started && (r_div == c_div_last);
        // End of the high half of the final bit of the final byte.
        w_last = w_half_done && r_sclk && (r_bit == 3'd0) &&
                 (r_bytes_left == 4'd1);
        if (w_last) begin
          w_next_state = S_GAP;
        end
      end
      S_GAP: begin
        w_gap_done = (r_gap == c_gap_last);
        if (w_gap_done) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Datapath: ROM read port, shift/prefetch registers and SPI pins
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_shift      <= 8'h00;
      r_pref       <= 8'h00;
      r_inv_mask   <= 8'h00;
      r_bit        <= 3'd0;
      r_bytes_left <= 4'd0;
      r_div        <= 8'd0;
      r_gap        <= 9'd0;
      r_started    <= 1'b0;
      r_pf_issue   <= 1'b0;
      r_pf_cap     <= 1'b0;
      r_rom_ad     <= 11'h000;
      r_rom_ce     <= 1'b0;
      r_sclk       <= 1'b0;
      r_mosi       <= 1'b0;
      r_cs_n       <= 1'b1;
      r_dc         <= 1'b0;
    end else begin
      // Single-cycle read strobe; prefetch data appears two edges later.
      r_rom_ce   <= 1'b0;
      r_pf_issue <= 1'b0;
      r_pf_cap   <= r_pf_issue;
      if (r_pf_cap) begin
        r_pref <= rom_dout ^ r_inv_mask;
      end

      case (r_state)
        S_IDLE: begin
          r_started <= 1'b0;
          if (w_accept) begin
            r_dc       <= ~req.in_cmd;
            r_inv_mask <= w_invert_mask;
            if (req.in_cmd) begin
              r_shift      <= req.in_data;
              r_bytes_left <= 4'd1;
            end else begin
              // Address arithmetic is 11 bit, so glyphs wrap around the ROM.
              r_rom_ad     <= FONT_BASE + {req.in_data, 3'b000};
              r_rom_ce     <= 1'b1;
              r_bytes_left <= 4'd8;
            end
          end
        end

        S_FETCH: begin
          // ROM latency cycle; nothing to do.
        end

        S_LOAD: begin
          r_shift <= rom_dout ^ r_inv_mask;
        end

        S_SHIFT: begin
          if (!r_started) begin
            // cs_n and the MSB go out one full half-period ahead of SCLK.
            r_started <= 1'b1;
            r_cs_n    <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= r_shift[7];
            r_bit     <= 3'd7;
            r_div     <= 8'd0;
            if (r_bytes_left > 4'd1) begin
              r_rom_ad   <= r_rom_ad + 11'd1;
              r_rom_ce   <= 1'b1;
              r_pf_issue <= 1'b1;
            end
          end else if (w_half_done) begin
            r_div <= 8'd0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              // Falling edge: MOSI advances together with SCLK going low.
              r_sclk <= 1'b0;
              if (r_bit != 3'd0) begin
                r_bit  <= r_bit - 3'd1;
                r_mosi <= r_shift[r_bit - 3'd1];
              end else if (r_bytes_left > 4'd1) begin
                // Byte boundary: continue seamlessly from the prefetch
                // buffer and start fetching the byte after it.
                r_shift      <= r_pref;
                r_mosi       <= r_pref[7];
                r_bit        <= 3'd7;
                r_bytes_left <= r_bytes_left - 4'd1;
                if (r_bytes_left > 4'd2) begin
                  r_rom_ad   <= r_rom_ad + 11'd1;
                  r_rom_ce   <= 1'b1;
                  r_pf_issue <= 1'b1;
                end
              end else begin
                r_cs_n <= 1'b1;
                r_mosi <= 1'b0;
                r_gap  <= 9'd0;
              end
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end

        S_GAP: begin
          r_gap <= r_gap + 9'd1;
        end

        default: begin
        end
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign req.in_ready = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign rom_ad       = r_rom_ad;
  assign rom_ce       = r_rom_ce;
  assign rom_oce      = 1'b1;
  assign rom_reset    = ~reset_n;
  assign spi_sclk     = r_sclk;
  assign spi_mosi     = r_mosi;
  assign spi_cs_n     = r_cs_n;
  assign spi_dc       = r_dc;

endmodule
`default_nettype wire

// File: tb/tb_glyph_spi_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_glyph_spi_streamer                                         |
// | Purpose  : Directed self-checking bench. dut0: SCLK_DIV=2, FONT_BASE=0;  |
// |            dut1: SCLK_DIV=1, FONT_BASE=11'h7F8 (address wrap).           |
// |            Both share a behavioural 2 KB ROM image and SPI monitors.     |
// |            Build with GLYPH_INVERT_EN to exercise glyph inversion.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_glyph_spi_streamer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  glyph_spi_streamer_if if0 ();
  glyph_spi_streamer_if if1 ();

  logic        busy0, busy1;
  logic [10:0] rom_ad0, rom_ad1;
  logic        rom_ce0, rom_ce1, rom_oce0, rom_oce1, rom_reset0, rom_reset1;
  logic [7:0]  rom_dout0 = 8'h00;
  logic [7:0]  rom_dout1 = 8'h00;
  logic        spi_sclk0, spi_mosi0, spi_cs_n0, spi_dc0;
  logic        spi_sclk1, spi_mosi1, spi_cs_n1, spi_dc1;

  glyph_spi_streamer #(.FONT_BASE(11'h000), .SCLK_DIV(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .req(if0), .busy(busy0),
    .rom_ad(rom_ad0), .rom_ce(rom_ce0), .rom_oce(rom_oce0),
    .rom_reset(rom_reset0), .rom_dout(rom_dout0),
    .spi_sclk(spi_sclk0), .spi_mosi(spi_mosi0), .spi_cs_n(spi_cs_n0),
    .spi_dc(spi_dc0)
  );

  glyph_spi_streamer #(.FONT_BASE(11'h7F8), .SCLK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(if1), .busy(busy1),
    .rom_ad(rom_ad1), .rom_ce(rom_ce1), .rom_oce(rom_oce1),
    .rom_reset(rom_reset1), .rom_dout(rom_dout1),
    .spi_sclk(spi_sclk1), .spi_mosi(spi_mosi1), .spi_cs_n(spi_cs_n1),
    .spi_dc(spi_dc1)
  );

  // ROM image and synchronous one-cycle read ports
  logic [7:0] rom_mem [0:2047];
  always @(posedge clk) if (rom_ce0) rom_dout0 <= rom_mem[rom_ad0];
  always @(posedge clk) if (rom_ce1) rom_dout1 <= rom_mem[rom_ad1];

  // Counters
  int n_checks = 0;
  int n_pass   = 0;

  // Monitors
  int          cap_cnt0, cap_cnt1, cs_fall0, cs_rise0, dc_bad0, acc_cnt0;
  logic [63:0] cap_word0, cap_word1;
  logic        dc_or0, dc_and0;
  time         t_rise0, t_rise1, t_csfall0, t_csrise0, t_ready0;
  logic [10:0] rd_q0[$];
  logic [10:0] rd_q1[$];
  time         t_acc0[$];
  logic        hs0 = 1'b0;

  always @(posedge spi_sclk0) if (!spi_cs_n0) begin
    if (cap_cnt0 == 0) t_rise0 = $time;
    cap_word0 = {cap_word0[62:0], spi_mosi0};
    cap_cnt0++;
    dc_or0  = dc_or0 | spi_dc0;
    dc_and0 = dc_and0 & spi_dc0;
  end
  always @(posedge spi_sclk1) if (!spi_cs_n1) begin
    if (cap_cnt1 == 0) t_rise1 = $time;
    cap_word1 = {cap_word1[62:0], spi_mosi1};
    cap_cnt1++;
  end
  always @(negedge spi_cs_n0) begin cs_fall0++; t_csfall0 = $time; end
  always @(posedge spi_cs_n0) begin cs_rise0++; t_csrise0 = $time; end
  always @(posedge if0.in_ready) t_ready0 = $time;
  always @(spi_dc0) if (!spi_cs_n0) dc_bad0++;
  always @(posedge clk) if (rom_ce0) rd_q0.push_back(rom_ad0);
  always @(posedge clk) if (rom_ce1) rd_q1.push_back(rom_ad1);
  always @(negedge clk) hs0 = if0.in_valid && if0.in_ready;
  always @(posedge clk) if (hs0) begin acc_cnt0++; t_acc0.push_back($time); end

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic clr_mon();
    cap_cnt0 = 0; cap_cnt1 = 0; cap_word0 = '0; cap_word1 = '0;
    cs_fall0 = 0; cs_rise0 = 0; dc_bad0 = 0; acc_cnt0 = 0;
    dc_or0 = 1'b0; dc_and0 = 1'b1;
    t_rise0 = 0; t_rise1 = 0; t_csfall0 = 0; t_csrise0 = 0; t_ready0 = 0;
    rd_q0.delete(); rd_q1.delete(); t_acc0.delete();
  endtask

  function automatic logic [63:0] glyph_word(input logic [10:0] base);
    logic [63:0] w = '0;
    for (int k = 0; k < 8; k++) w = {w[55:0], rom_mem[11'(base + 11'(k))]};
    return w;
  endfunction

  function automatic logic rdy(input int which);
    return (which != 0) ? if1.in_ready : if0.in_ready;
  endfunction

  function automatic logic bsy(input int which);
    return (which != 0) ? busy1 : busy0;
  endfunction

  task automatic send(input int which, input logic cmd, input logic [7:0] data,
                      input logic inv, output time t0);
    bit ok = 0;
    @(posedge clk); #1;
    if (which != 0) begin
      if1.in_valid = 1'b1; if1.in_cmd = cmd; if1.in_data = data;
    end else begin
      if0.in_valid = 1'b1; if0.in_cmd = cmd; if0.in_data = data;
    end
`ifdef GLYPH_INVERT_EN
    if (which != 0) if1.invert = inv; else if0.invert = inv;
`else
    if (inv) $display("note: invert ignored in this build");
`endif
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (rdy(which)) ok = 1;
    end
    @(posedge clk);
    t0 = $time;
    #1;
    if0.in_valid = 1'b0;
    if1.in_valid = 1'b0;
    if (!ok) check_val("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input int which);
    bit ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (rdy(which) && !bsy(which)) ok = 1;
    end
    if (!ok) check_val("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    time t0;
    bit  ok;
    for (int a = 0; a < 2048; a++) rom_mem[a] = 8'(a * 29 + (a >> 8) * 71 + 60);
`ifdef GLYPH_INVERT_EN
    for (int a = 0; a < 8; a++) rom_mem[a] = 8'h00;
    if0.invert = 1'b0; if1.invert = 1'b0;
`endif
    if0.in_valid = 1'b0; if0.in_cmd = 1'b0; if0.in_data = 8'h00;
    if1.in_valid = 1'b0; if1.in_cmd = 1'b0; if1.in_data = 8'h00;
    clr_mon();

    // ---------------- reset values ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rom_reset_asserted", 64'(rom_reset0), 64'd1);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("reset_flags", 64'({if0.in_ready, busy0, rom_ce0, spi_sclk0,
                                  spi_mosi0, spi_cs_n0, spi_dc0}), 64'b1000010);
    check_val("reset_rom_ad", 64'(rom_ad0), 64'h0);
    check_val("rom_oce_rom_reset", 64'({rom_oce0, rom_reset0}), 64'b10);

    // ---------------- char 0x41 ----------------
    clr_mon();
    send(0, 1'b0, 8'h41, 1'b0, t0);
    wait_done(0);
    check_val("char_latency_ns", 64'(t_rise0 - t0), 64'd50);
    check_val("char_bits", 64'(cap_cnt0), 64'd64);
    check_val("char_word", cap_word0, glyph_word(11'h208));
    check_val("char_dc_all_1", 64'(dc_and0), 64'd1);
    check_val("char_cs_edges", 64'({cs_fall0[7:0], cs_rise0[7:0]}), 64'h0101);
    check_val("char_cs_low_ns", 64'(t_csrise0 - t_csfall0), 64'd2560);
    check_val("char_reads", 64'(rd_q0.size()), 64'd8);
    for (int k = 0; k < 8; k++)
      check_val($sformatf("char_rd_addr%0d", k),
                (rd_q0.size() > k) ? 64'(rd_q0[k]) : 64'hDEAD, 64'(11'h208 + k));

    // ---------------- command 0xAF ----------------
    clr_mon();
    send(0, 1'b1, 8'hAF, 1'b0, t0);
    wait_done(0);
    check_val("cmd_bits", 64'(cap_cnt0), 64'd8);
    check_val("cmd_word", cap_word0, 64'hAF);
    check_val("cmd_dc_all_0", 64'(dc_or0), 64'd0);
    check_val("cmd_latency_ns", 64'(t_rise0 - t0), 64'd30);
    check_val("cmd_gap_ns", 64'(t_ready0 - t_csrise0), 64'd40);
    check_val("cmd_no_reads", 64'(rd_q0.size()), 64'd0);

    // ---------------- back-to-back: cmd then char ----------------
    clr_mon();
    @(posedge clk); #1;
    if0.in_valid = 1'b1; if0.in_cmd = 1'b1; if0.in_data = 8'hAF;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #1;
      if (acc_cnt0 >= 1) ok = 1;
    end
    if0.in_cmd = 1'b0; if0.in_data = 8'h41;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk); #1;
      if (acc_cnt0 >= 2) ok = 1;
    end
    if0.in_valid = 1'b0;
    if (!ok) check_val("b2b_timeout", 64'd0, 64'd1);
    wait_done(0);
    check_val("b2b_accepts", 64'(acc_cnt0), 64'd2);
    check_val("b2b_spacing_ns",
              (t_acc0.size() >= 2) ? 64'(t_acc0[1] - t_acc0[0]) : 64'd0, 64'd380);
    check_val("b2b_dc_change_cs_low", 64'(dc_bad0), 64'd0);
    check_val("b2b_bits", 64'(cap_cnt0), 64'd72);
    check_val("b2b_char_word", cap_word0, glyph_word(11'h208));

    // ---------------- reset during bit 3 of glyph byte 5 ----------------
    clr_mon();
    send(0, 1'b0, 8'h41, 1'b0, t0);
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (cap_cnt0 >= 45) ok = 1;
    end
    check_val("abort_bits_before", 64'(cap_cnt0), 64'd45);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check_val("abort_cs_n", 64'(spi_cs_n0), 64'd1);
    check_val("abort_sclk", 64'(spi_sclk0), 64'd0);
    check_val("abort_in_ready", 64'(if0.in_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    clr_mon();
    send(0, 1'b0, 8'h42, 1'b0, t0);
    wait_done(0);
    check_val("after_abort_bits", 64'(cap_cnt0), 64'd64);
    check_val("after_abort_word", cap_word0, glyph_word(11'h210));
    check_val("after_abort_first_rd",
              (rd_q0.size() > 0) ? 64'(rd_q0[0]) : 64'hDEAD, 64'h210);

    // ---------------- FONT_BASE wrap on dut1 ----------------
    clr_mon();
    send(1, 1'b0, 8'h01, 1'b0, t0);
    wait_done(1);
    check_val("wrap_latency_ns", 64'(t_rise1 - t0), 64'd40);
    check_val("wrap_bits", 64'(cap_cnt1), 64'd64);
    check_val("wrap_word", cap_word1, glyph_word(11'h000));
    for (int k = 0; k < 8; k++)
      check_val($sformatf("wrap_rd_addr%0d", k),
                (rd_q1.size() > k) ? 64'(rd_q1[k]) : 64'hDEAD, 64'(k));

`ifdef GLYPH_INVERT_EN
    // ---------------- inversion ----------------
    clr_mon();
    send(0, 1'b0, 8'h00, 1'b1, t0);
    wait_done(0);
    check_val("inv_glyph_word", cap_word0, 64'hFFFF_FFFF_FFFF_FFFF);
    check_val("inv_glyph_bits", 64'(cap_cnt0), 64'd64);
    clr_mon();
    send(0, 1'b1, 8'h00, 1'b1, t0);
    wait_done(0);
    check_val("inv_cmd_word", cap_word0, 64'h00);
    check_val("inv_cmd_bits", 64'(cap_cnt0), 64'd8);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
